fifo_p_pkt: RTL and testbench
=============================

Name: fifo_p_pkt

Overview:
- Store-and-forward byte-stream packet FIFO.
- Accepts sop/eop-framed byte packets, buffers each complete packet, then forwards it back-to-back on the output.
- Discards packets whose length is outside [MIN_LEN, MAX_LEN], or that overflow the buffer, so downstream logic only ever sees whole, length-valid packets.

Parameters:
- DW, 8, data width in bits.
- AW, 11, data buffer address width; depth = 2**AW = 2048 entries.
- MIN_LEN, 64, minimum legal packet length in bytes (inclusive).
- MAX_LEN, 1536, maximum legal packet length in bytes (inclusive).
- PKT_AW, 4, packet-descriptor FIFO address width; holds 16 committed packets.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- din  in  DW  input byte.
- din_sop  in  1  first byte of packet; qualified by din_vld.
- din_eop  in  1  last byte of packet; qualified by din_vld.
- din_vld  in  1  din valid this cycle.
- dout  out  DW  output byte.
- dout_vld  out  1  dout valid.
- dout_sop  out  1  first output byte of packet.
- dout_eop  out  1  last output byte of packet.

Behaviour:
- Reset (rst_n=0 at a clock edge): dout=0, dout_vld=0, dout_sop=0, dout_eop=0; pointers, counters and descriptor FIFO cleared; write FSM to IDLE.
- No backpressure. The input may present one byte per cycle indefinitely.
- Write FSM states are IDLE and RX.
- IDLE:
  - din_vld & din_sop: write the byte at wr_ptr, save start pointer, set len=1, go to RX.
  - din_vld without sop: byte ignored.
  - sop & eop on the same beat: one-byte packet, checked immediately.
- RX, on each din_vld:
  - Write the byte and increment len. len saturates at MAX_LEN+1.
  - din_sop in RX: current packet aborted (wr_ptr rewound to start), new packet begins with this byte.
  - din_eop: length check.
- Length check at eop:
  - MIN_LEN <= len <= MAX_LEN and no overflow: commit. wr_ptr advances past the packet; a descriptor (len) is pushed to the descriptor FIFO.
  - Otherwise: drop. wr_ptr restored to the saved start; nothing is pushed.
  - Either way, return to IDLE.
- Overflow:
  - A byte arriving when committed-but-unread bytes plus current packet bytes = 2**AW sets an overflow flag. The byte is not written.
  - A packet with the overflow flag set is dropped at eop.
  - The descriptor FIFO being full at eop also drops the packet.
- Read side:
  - When idle and the descriptor FIFO is not empty, pop a descriptor and stream len bytes from rd_ptr, one per cycle with no gaps.
  - Outputs are registered. dout_sop is on the first byte, dout_eop on byte len.
  - Next packet may start the cycle after dout_eop.
- Latency: first dout_vld of a packet is 2 cycles after the clock edge that sampled its din_eop, provided the read side is idle.
- Pointers wrap modulo 2**AW. Reading and writing proceed concurrently; the read side only touches committed bytes.
- Data memory: simple dual-port, 1-cycle read latency.

Optional Feature:
- Macro: FIFO_P_DROP_CNT_EN.
- With it defined:
  - Extra output port drop_cnt (out, 16), a saturating count of dropped packets from any cause.
  - Counter increments once per drop, in the cycle after the drop decision.
  - Reset value 0.
- Without it: no port and no counter logic.

Test Plan:
- Reset: rst_n low 3 cycles with din_vld=0 -> all outputs 0; no dout_vld for 10 cycles after release.
- Short packet: 35-byte packet, bytes 1..35 -> dropped; dout_vld stays 0; drop_cnt=1 if enabled.
- Legal packet: 1532 bytes, din=i mod 256 -> 1532 contiguous dout_vld beats; dout matches input order; sop on the first beat, eop on the last; first beat 2 cycles after the din_eop edge.
- Long packet: 1559 bytes -> dropped; no output; a following legal 64-byte packet is output intact (pointer rewind verified).
- Back-to-back: two 100-byte packets with no idle cycle between -> two 100-beat output packets, each framed correctly, no data corruption.
- Overflow and malformed framing:
  - Write a 1536-byte legal packet and, while it is being read, a second 1536-byte packet -> both output.
  - A sop mid-packet aborts the first packet; only the second is output.

Source files
------------

// File: rtl/fifo_p_pkt.sv
// -----------------------------------------------------------------------------
// fifo_p_pkt -- store-and-forward byte-stream packet FIFO.
//
// Incoming sop/eop-framed packets are written into a circular data buffer.
// When a packet's eop arrives, it is committed only if all of these hold:
//   - its length is within [MIN_LEN, MAX_LEN];
//   - no byte of it was lost to a full buffer;
//   - the descriptor FIFO has room.
// Committing pushes the packet length into a small descriptor FIFO.
// Otherwise the write pointer is rewound and the packet vanishes.
// The read side pops descriptors and streams each packet gap-free.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   synchronous active-low reset
//   din      in   [DW-1:0] input byte
//   din_sop  in   first byte of packet (qualified by din_vld)
//   din_eop  in   last byte of packet (qualified by din_vld)
//   din_vld  in   input byte valid
//   dout     out  [DW-1:0] output byte (0 when not valid)
//   dout_vld out  output byte valid
//   dout_sop out  first output byte of packet
//   dout_eop out  last output byte of packet
//   drop_cnt out  [15:0] saturating dropped-packet count
//                 (only with FIFO_P_DROP_CNT_EN defined)
//
// Optional feature macro: FIFO_P_DROP_CNT_EN
// -----------------------------------------------------------------------------
module fifo_p_pkt #(
  parameter int DW      = 8,
  parameter int AW      = 11,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1536,
  parameter int PKT_AW  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] din,
  input  logic          din_sop,
  input  logic          din_eop,
  input  logic          din_vld,
  output logic [DW-1:0] dout,
  output logic          dout_vld,
  output logic          dout_sop,
  output logic          dout_eop
`ifdef FIFO_P_DROP_CNT_EN
  ,
  output logic [15:0]   drop_cnt
`endif
);

  // Length counter must hold MAX_LEN+1 (the saturation value).
  localparam int LW = $clog2(MAX_LEN + 2);
  localparam logic [LW-1:0]   LEN_MIN   = LW'(MIN_LEN);
  localparam logic [LW-1:0]   LEN_MAX   = LW'(MAX_LEN);
  localparam logic [LW-1:0]   LEN_SAT   = LW'(MAX_LEN + 1);
  localparam logic [LW-1:0]   LEN_ONE   = LW'(1);
  localparam logic [AW:0]     PTR_ONE   = (AW+1)'(1);
  localparam logic [AW:0]     MEM_FULL  = (AW+1)'(2**AW);
  localparam logic [PKT_AW:0] DESC_ONE  = (PKT_AW+1)'(1);
  localparam logic [PKT_AW:0] DESC_FULL = (PKT_AW+1)'(2**PKT_AW);

  typedef enum logic {ST_IDLE, ST_RX} wr_state_t;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_mem_q;
  logic [LW-1:0] r_desc_mem [2**PKT_AW];

  // ---------------------------------------------------------------------------
  // Write side state
  // ---------------------------------------------------------------------------
  wr_state_t   r_wr_state, w_wr_state_next;
  // Pointers carry one extra bit so a completely full buffer is distinguishable
  // from an empty one.
  logic [AW:0]   r_wr_ptr, w_wr_ptr_next;
  logic [AW:0]   r_start_ptr, w_start_ptr_next;  // first byte of packet in progress
  logic [LW-1:0] r_len, w_len_next;
  logic          r_ovf, w_ovf_next;

  logic          w_new_pkt, w_active, w_eop, w_full, w_wr_en;
  logic          w_len_ok, w_ovf_cur, w_commit, w_drop;
  logic [AW:0]   w_base_ptr, w_ptr_after;
  logic [LW-1:0] w_len_cur;

  // ---------------------------------------------------------------------------
  // Descriptor FIFO / read side state
  // ---------------------------------------------------------------------------
  logic [PKT_AW:0] r_desc_wp, r_desc_rp;
  logic            w_desc_full, w_desc_empty;

  logic [AW:0]     r_rd_ptr;
  logic            r_rd_busy;
  logic [LW-1:0]   r_rd_rem;          // bytes still to fetch after the current one
  logic            w_pop, w_issue, w_iss_last;
  logic [LW-1:0]   w_pop_len;

  logic            r_iss_vld, r_iss_sop, r_iss_eop;
  logic [DW-1:0]   r_dout;
  logic            r_dout_vld, r_dout_sop, r_dout_eop;

  // ---------------------------------------------------------------------------
  // Write datapath
  // ---------------------------------------------------------------------------
  assign w_new_pkt = din_vld & din_sop;
  assign w_active  = din_vld & (din_sop | (r_wr_state == ST_RX));
  assign w_eop     = w_active & din_eop;

  // A sop always (re)starts at the saved start pointer: in IDLE it equals the
  // write pointer, in RX it rewinds over the aborted packet.
  assign w_base_ptr  = w_new_pkt ? r_start_ptr : r_wr_ptr;

  // Occupancy = committed-unread bytes + bytes of the packet in progress.
  assign w_full      = (w_base_ptr - r_rd_ptr) == MEM_FULL;
  assign w_wr_en     = w_active & ~w_full;
  assign w_ptr_after = w_wr_en ? (w_base_ptr + PTR_ONE) : w_base_ptr;

  assign w_len_cur = w_new_pkt          ? LEN_ONE :
                     (r_len == LEN_SAT) ? r_len   : (r_len + LEN_ONE);
  assign w_ovf_cur = w_full | (~w_new_pkt & r_ovf);
  assign w_len_ok  = (w_len_cur >= LEN_MIN) && (w_len_cur <= LEN_MAX);

  always_comb begin
    w_wr_state_next  = r_wr_state;
    w_wr_ptr_next    = r_wr_ptr;
    w_start_ptr_next = r_start_ptr;
    w_len_next       = r_len;
    w_ovf_next       = r_ovf;
    w_commit         = 1'b0;
    w_drop           = 1'b0;
    if (w_active) begin
      if (w_eop) begin
        if (w_len_ok && !w_ovf_cur && !w_desc_full) begin
          w_commit         = 1'b1;
          w_wr_ptr_next    = w_ptr_after;
          w_start_ptr_next = w_ptr_after;
        end else begin
          w_drop        = 1'b1;
          w_wr_ptr_next = r_start_ptr;
        end
        w_len_next      = '0;
        w_ovf_next      = 1'b0;
        w_wr_state_next = ST_IDLE;
      end else begin
        w_wr_ptr_next   = w_ptr_after;
        w_len_next      = w_len_cur;
        w_ovf_next      = w_ovf_cur;
        w_wr_state_next = ST_RX;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_state  <= ST_IDLE;
      r_wr_ptr    <= '0;
      r_start_ptr <= '0;
      r_len       <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_wr_state  <= w_wr_state_next;
      r_wr_ptr    <= w_wr_ptr_next;
      r_start_ptr <= w_start_ptr_next;
      r_len       <= w_len_next;
      r_ovf       <= w_ovf_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_base_ptr[AW-1:0]] <= din;
    end
  end

  // ---------------------------------------------------------------------------
  // Descriptor FIFO (small, read combinationally)
  // ---------------------------------------------------------------------------
  assign w_desc_full  = (r_desc_wp - r_desc_rp) == DESC_FULL;
  assign w_desc_empty = (r_desc_wp == r_desc_rp);
  assign w_pop_len    = r_desc_mem[r_desc_rp[PKT_AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_desc_mem[r_desc_wp[PKT_AW-1:0]] <= w_len_cur;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_desc_wp <= '0;
      r_desc_rp <= '0;
    end else begin
      if (w_commit) r_desc_wp <= r_desc_wp + DESC_ONE;
      if (w_pop)    r_desc_rp <= r_desc_rp + DESC_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Read side: fetch one byte per cycle, two register stages to the outputs
  // (RAM read register, then output register).
  // ---------------------------------------------------------------------------
  assign w_pop      = ~r_rd_busy & ~w_desc_empty;
  assign w_issue    = w_pop | r_rd_busy;
  assign w_iss_last = w_pop ? (w_pop_len == LEN_ONE) : (r_rd_rem == LEN_ONE);

  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_mem_q <= r_mem[r_rd_ptr[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_ptr   <= '0;
      r_rd_busy  <= 1'b0;
      r_rd_rem   <= '0;
      r_iss_vld  <= 1'b0;
      r_iss_sop  <= 1'b0;
      r_iss_eop  <= 1'b0;
      r_dout     <= '0;
      r_dout_vld <= 1'b0;
      r_dout_sop <= 1'b0;
      r_dout_eop <= 1'b0;
    end else begin
      if (w_pop) begin
        r_rd_rem  <= w_pop_len - LEN_ONE;
        r_rd_busy <= (w_pop_len != LEN_ONE);
      end else if (r_rd_busy) begin
        r_rd_rem <= r_rd_rem - LEN_ONE;
        if (r_rd_rem == LEN_ONE) r_rd_busy <= 1'b0;
      end
      if (w_issue) r_rd_ptr <= r_rd_ptr + PTR_ONE;

      r_iss_vld  <= w_issue;
      r_iss_sop  <= w_pop;
      r_iss_eop  <= w_issue & w_iss_last;

      r_dout     <= r_iss_vld ? r_mem_q : '0;
      r_dout_vld <= r_iss_vld;
      r_dout_sop <= r_iss_sop;
      r_dout_eop <= r_iss_eop;
    end
  end

  assign dout     = r_dout;
  assign dout_vld = r_dout_vld;
  assign dout_sop = r_dout_sop;
  assign dout_eop = r_dout_eop;

`ifdef FIFO_P_DROP_CNT_EN
  // Counts eop-time drop decisions (length, overflow, descriptor FIFO full).
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_fifo_p_pkt.sv
// -----------------------------------------------------------------------------
// tb_fifo_p_pkt -- directed self-checking bench for fifo_p_pkt.
// A negedge monitor collects every output beat; the directed sequence in the
// main initial block drives packets and compares the collected beats against
// hand-derived expectations (data = base + index, framing, cycle timing).
// -----------------------------------------------------------------------------
module tb_fifo_p_pkt;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = '0;
  logic       din_sop = 1'b0;
  logic       din_eop = 1'b0;
  logic       din_vld = 1'b0;
  logic [7:0] dout;
  logic       dout_vld;
  logic       dout_sop;
  logic       dout_eop;
`ifdef FIFO_P_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_eop_edge = 0;

  typedef struct {
    logic [7:0] d;
    logic       sop;
    logic       eop;
    int         cyc;
  } beat_t;

  beat_t q[$];

  fifo_p_pkt dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .din_sop  (din_sop),
    .din_eop  (din_eop),
    .din_vld  (din_vld),
    .dout     (dout),
    .dout_vld (dout_vld),
    .dout_sop (dout_sop),
    .dout_eop (dout_eop)
`ifdef FIFO_P_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dout_vld === 1'b1) q.push_back('{dout, dout_sop, dout_eop, cyc});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_empty(input string tag);
    chk(tag, q.size(), 0);
    q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      din     = '0;
      din_vld = 1'b0;
      din_sop = 1'b0;
      din_eop = 1'b0;
    end
  endtask

  // Drives len bytes with value (base+i) mod 256; records the eop sampling edge.
  task automatic send(input int len, input int base, input bit with_eop);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      din     = 8'((base + i) & 255);
      din_vld = 1'b1;
      din_sop = (i == 0);
      din_eop = with_eop && (i == len - 1);
    end
    if (with_eop) last_eop_edge = cyc + 1;
  endtask

  task automatic check_pkt(input string tag, input int len, input int base, input int first_cyc);
    int n;
    int derr = 0;
    int serr = 0;
    int eerr = 0;
    int gerr = 0;
    int c0 = -1;
    beat_t b;
    n = (q.size() < len) ? q.size() : len;
    chk({tag, " beats"}, n, len);
    for (int i = 0; i < n; i++) begin
      b = q.pop_front();
      if (i == 0) c0 = b.cyc;
      if (b.d !== 8'((base + i) & 255)) derr++;
      if (b.sop !== (i == 0)) serr++;
      if (b.eop !== (i == len - 1)) eerr++;
      if (b.cyc != c0 + i) gerr++;
    end
    chk({tag, " first_cycle"}, c0, first_cyc);
    chk({tag, " data_errs"}, derr, 0);
    chk({tag, " sop_errs"}, serr, 0);
    chk({tag, " eop_errs"}, eerr, 0);
    chk({tag, " gap_errs"}, gerr, 0);
  endtask

  initial begin
    int e1;
    int e2;

    // Reset: 3 cycles low, inputs idle
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset dout", dout, 0);
    chk("reset dout_vld", dout_vld, 0);
    chk("reset dout_sop", dout_sop, 0);
    chk("reset dout_eop", dout_eop, 0);
`ifdef FIFO_P_DROP_CNT_EN
    chk("reset drop_cnt", drop_cnt, 0);
`endif
    rst_n = 1'b1;
    idle(10);
    chk_empty("post_reset no output");

    // Short packet (35 bytes, values 1..35) is dropped
    send(35, 1, 1'b1);
    idle(10);
    chk_empty("short35 dropped");
`ifdef FIFO_P_DROP_CNT_EN
    chk("drop_cnt after short", drop_cnt, 1);
`endif

    // Legal 1532-byte packet, din = i mod 256
    send(1532, 0, 1'b1);
    e1 = last_eop_edge;
    idle(1545);
    check_pkt("legal1532", 1532, 0, e1 + 2);
    chk_empty("legal1532 no extra");

    // Long packet dropped, following minimum-length packet intact
    send(1559, 0, 1'b1);
    idle(10);
    chk_empty("long1559 dropped");
    send(64, 8'h40, 1'b1);
    e1 = last_eop_edge;
    idle(80);
    check_pkt("min64 after long", 64, 8'h40, e1 + 2);
    chk_empty("min64 no extra");

    // Just below minimum, and a single sop+eop byte: both dropped
    send(63, 8'h11, 1'b1);
    idle(10);
    chk_empty("len63 dropped");
    send(1, 8'h07, 1'b1);
    idle(5);
    chk_empty("len1 dropped");

    // Back-to-back 100-byte packets with no idle between them
    send(100, 8'h10, 1'b1);
    e1 = last_eop_edge;
    send(100, 8'h80, 1'b1);
    e2 = last_eop_edge;
    idle(120);
    check_pkt("b2b first", 100, 8'h10, e1 + 2);
    check_pkt("b2b second", 100, 8'h80, e2 + 2);
    chk_empty("b2b no extra");

    // Two maximum-length packets, second written while first is read
    send(1536, 0, 1'b1);
    e1 = last_eop_edge;
    send(1536, 8'h55, 1'b1);
    e2 = last_eop_edge;
    idle(1550);
    check_pkt("max1536 first", 1536, 0, e1 + 2);
    check_pkt("max1536 second", 1536, 8'h55, e2 + 2);
    chk_empty("max1536 no extra");

    // sop in the middle of a packet aborts it; only the new packet appears
    send(50, 8'h20, 1'b0);
    send(70, 8'hA0, 1'b1);
    e1 = last_eop_edge;
    idle(90);
    check_pkt("abort second", 70, 8'hA0, e1 + 2);
    chk_empty("abort no extra");

`ifdef FIFO_P_DROP_CNT_EN
    chk("drop_cnt final", drop_cnt, 4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
